// File: rtl/d_ff_pkg.sv
// Shared constants and helpers for the d_ff register family.
// Optional load enable is selected with the D_FF_LOAD_EN macro.
package d_ff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 1;
  localparam int DFF_MAX_WIDTH     = 256;

  // All-zero reset vector; callers size-cast it down to their own width.
  function automatic logic [DFF_MAX_WIDTH-1:0] dffZeroReset(input int width);
    logic [DFF_MAX_WIDTH-1:0] vec;
    vec = '0;
    for (int i = 0; i < width && i < DFF_MAX_WIDTH; i++) begin
      vec[i] = 1'b0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/d_ff_bit.sv
// Single-bit storage cell with synchronous active-high reset.
// Optional load enable (port en) when D_FF_LOAD_EN is defined.
module d_ff_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
`ifdef D_FF_LOAD_EN
  ,
  input  logic en
`endif
);

  logic q_q;
  logic q_d;

  // Without the enable the cell reloads on every non-reset edge.
  always_comb begin
    q_d = d;
`ifdef D_FF_LOAD_EN
    if (!en) begin
      q_d = q_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/d_ff.sv
// Parameterised-width D register built from per-bit d_ff_bit cells.
// Optional load enable (port en) when D_FF_LOAD_EN is defined.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(dffZeroReset(WIDTH))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef D_FF_LOAD_EN
  ,
  input  logic             en
`endif
);

  // Each cell takes its own bit of the reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_bit #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .d    (d[i]),
      .q    (q[i])
`ifdef D_FF_LOAD_EN
      ,
      .en   (en)
`endif
    );
  end

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: single register, 4-stage chain, non-zero reset value, 1-bit width.
// Covers the D_FF_LOAD_EN enable behaviour when that macro is defined.
module tb_d_ff;

`ifdef D_FF_LOAD_EN
  localparam bit HAS_EN = 1'b1;
`else
  localparam bit HAS_EN = 1'b0;
`endif
  localparam logic [4:0] RV = 5'b01010;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] dIn;
  logic en;
  logic [4:0] mainQ;
  logic [4:0] rvQ;
  logic bitQ;
  logic [4:0] chain [STAGES+1];

  int total = 0;
  int bad = 0;

  logic [4:0] expMain;
  logic [4:0] expRv;
  logic expBit;
  logic [4:0] dHist[$];
  bit rstHist[$];

  always #5 clk = ~clk;

  d_ff #(5) u_main (
    .clk  (clk),
    .reset(reset),
    .d    (dIn),
    .q    (mainQ)
`ifdef D_FF_LOAD_EN
    ,
    .en   (en)
`endif
  );

  d_ff #(.WIDTH(5), .RESET_VALUE(RV)) u_rv (
    .clk  (clk),
    .reset(reset),
    .d    (dIn),
    .q    (rvQ)
`ifdef D_FF_LOAD_EN
    ,
    .en   (1'b1)
`endif
  );

  d_ff u_bit1 (
    .clk  (clk),
    .reset(reset),
    .d    (dIn[0]),
    .q    (bitQ)
`ifdef D_FF_LOAD_EN
    ,
    .en   (1'b1)
`endif
  );

  assign chain[0] = dIn;
  for (genvar s = 0; s < STAGES; s++) begin : g_chain
    d_ff #(5) u_stage (
      .clk  (clk),
      .reset(reset),
      .d    (chain[s]),
      .q    (chain[s+1])
`ifdef D_FF_LOAD_EN
      ,
      .en   (1'b1)
`endif
    );
  end

  // A chain stage is zero if any reset hit within its delay window, else the input from that many edges ago.
  function automatic logic [4:0] chainExp(input int stage);
    int n;
    n = dHist.size();
    for (int k = 0; k <= stage; k++) begin
      if (rstHist[n-1-k]) return 5'b00000;
    end
    return dHist[n-1-stage];
  endfunction

  task automatic applyStimulus(input logic r, input logic [4:0] dv, input logic ev);
    logic effEn;
    @(negedge clk);
    reset = r;
    dIn   = dv;
    en    = ev;
    @(posedge clk);
    #1;
    effEn = HAS_EN ? ev : 1'b1;
    if (r) begin
      expMain = 5'b00000;
      expRv   = RV;
      expBit  = 1'b0;
    end else begin
      if (effEn) expMain = dv;
      expRv  = dv;
      expBit = dv[0];
    end
    dHist.push_back(dv);
    rstHist.push_back(r);
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".main"}, mainQ, expMain);
    checkOutput({tag, ".rv"}, rvQ, expRv);
    checkOutput({tag, ".bit"}, {4'b0000, bitQ}, {4'b0000, expBit});
    for (int s = 0; s < STAGES; s++) begin
      checkOutput($sformatf("%s.chain%0d", tag, s), chain[s+1], chainExp(s));
    end
  endtask

  initial begin
    reset = 1'b1;
    dIn   = 5'b00000;
    en    = 1'b1;

    // Reset edge with data present
    applyStimulus(1'b1, 5'b10011, 1'b1);
    checkOutput("reset_main", mainQ, 5'b00000);
    checkOutput("reset_rv", rvQ, RV);
    checkAll("reset");

    // Release: one-cycle latency, then the chain walk
    applyStimulus(1'b0, 5'b10011, 1'b1);
    checkOutput("load_main", mainQ, 5'b10011);
    checkOutput("chain_e1_s0", chain[1], 5'b10011);
    checkOutput("chain_e1_s1", chain[2], 5'b00000);
    checkAll("e1");
    applyStimulus(1'b0, 5'b10011, 1'b1);
    checkOutput("chain_e2_s1", chain[2], 5'b10011);
    checkAll("e2");
    for (int e = 3; e <= 6; e++) begin
      applyStimulus(1'b0, 5'b00000, 1'b1);
      if (e == 3) checkOutput("zero_main", mainQ, 5'b00000);
      checkAll($sformatf("e%0d", e));
    end
    checkOutput("chain_e6_s3", chain[4], 5'b00000);

    // Reset mid-stream
    applyStimulus(1'b0, 5'b11111, 1'b1);
    checkOutput("pre_mid", mainQ, 5'b11111);
    applyStimulus(1'b1, 5'b10101, 1'b1);
    checkOutput("mid_reset", mainQ, 5'b00000);
    checkAll("mid_reset");
    applyStimulus(1'b0, 5'b10101, 1'b1);
    checkOutput("mid_release", mainQ, 5'b10101);

    // Non-zero reset value
    applyStimulus(1'b1, 5'b11111, 1'b1);
    checkOutput("rv_reset", rvQ, 5'b01010);
    applyStimulus(1'b0, 5'b00001, 1'b1);
    checkOutput("rv_load", rvQ, 5'b00001);
    checkAll("rv");

`ifdef D_FF_LOAD_EN
    // Load enable: hold, load, reset overrides hold
    applyStimulus(1'b0, 5'b00011, 1'b1);
    checkOutput("en_setup", mainQ, 5'b00011);
    applyStimulus(1'b0, 5'b11100, 1'b0);
    checkOutput("en_hold", mainQ, 5'b00011);
    applyStimulus(1'b0, 5'b11100, 1'b1);
    checkOutput("en_load", mainQ, 5'b11100);
    applyStimulus(1'b1, 5'b11100, 1'b0);
    checkOutput("en_reset", mainQ, 5'b00000);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), 5'($urandom), 1'($urandom_range(0, 1)));
      checkAll("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_ff.md
Name: d_ff

Overview:
- Parameterised-width, edge-triggered D register; the basic storage element of the processor datapath.
- Samples `d` on every rising clock edge and presents it on `q` one cycle later.
- Instantiated by pipeline and shift structures. Those users chain instances back to back, with `q` of one instance feeding `d` of the next, to form N-stage delay lines.
- The first parameter is the data width and is passed positionally by all users.

Parameters:
- WIDTH, default 1: number of bits stored. Must be 1 or more. Must remain the first declared parameter.
- RESET_VALUE, default all-zeros (WIDTH bits): value loaded into `q` on reset.

Ports:
- clk, input, 1: clock. All state changes occur on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- d, input, WIDTH: data to capture.
- q, output, WIDTH: registered data.
- en, input, 1: present only when D_FF_LOAD_EN is defined. Load enable, active-high.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, fixed for this block.
- At each rising edge of `clk`:
  - If `reset` = 1: `q` <= RESET_VALUE, regardless of `d` (and of `en` when present).
  - Otherwise: `q` <= `d`.
- Reset has priority over data and over enable.
- Latency is exactly 1 cycle: a value applied to `d` before edge k appears on `q` after edge k.
- `q` changes only at rising edges. There is no combinational path from `d` or `reset` to `q`.
- Asserting `reset` mid-stream clears `q` at the next edge only. After `reset` is released, the following edge captures `d` normally.
- Before the first reset edge, `q` is undefined (X in simulation). Users must reset before relying on `q`.
- All WIDTH bits are updated together; no bit-level masking.
- Chaining: M instances in series delay `d` by M cycles. Synchronous reset clears every stage on the same edge.
- With WIDTH = 1 the block behaves identically, with scalar-width ports.

Optional Feature:
- Macro: D_FF_LOAD_EN.
- When defined:
  - Adds the `en` input port.
  - At a rising edge with `reset` = 0: `en` = 1 gives `q` <= `d`; `en` = 0 makes `q` hold its previous value.
  - `reset` = 1 still forces RESET_VALUE whatever `en` is.
- When undefined:
  - No `en` port exists.
  - The register loads `d` on every non-reset edge.
  - Port list is exactly `clk`, `reset`, `d`, `q`, so existing wildcard and implicit port connections remain valid.

Decomposition:
- Shared package `d_ff_pkg`:
  - Constant DFF_DEFAULT_WIDTH = 1.
  - Helper function returning an all-zero reset vector for a given width.
- One natural sub-module, `d_ff_bit`: a single-bit register cell.
  - Ports: clk, reset, d, q, and en under the macro.
  - Its own 1-bit reset value.
- `d_ff` generates WIDTH `d_ff_bit` instances, each indexed by bit. Each cell receives its bit of RESET_VALUE.

Test Plan:
1. WIDTH=5, hold `reset`=1 with `d`=5'b10011 for one edge -> `q`=5'b00000.
2. WIDTH=5, release reset, `d`=5'b10011 -> after the next edge `q`=5'b10011. Then set `d`=0 -> after the following edge `q`=5'b00000 (1-cycle latency).
3. Chain of 4 instances, WIDTH=5:
   - Reset one edge, then drive 5'b10011 for two edges, then 0.
   - Stage i outputs 5'b10011 on edges i+1 and i+2 after reset release, and 0 otherwise. All stages are 0 after edge 6.
4. Reset mid-stream: with `q`=5'b11111, assert `reset` with `d`=5'b10101 -> `q`=0 at that edge. Deassert -> `q`=5'b10101 at the next edge.
5. RESET_VALUE=5'b01010, WIDTH=5: reset edge -> `q`=5'b01010. First non-reset edge with `d`=5'b00001 -> `q`=5'b00001.
6. With D_FF_LOAD_EN defined:
   - `en`=0, `d`=5'b11100 while `q`=5'b00011 -> `q` stays 5'b00011.
   - `en`=1 -> `q`=5'b11100.
   - `reset`=1 with `en`=0 -> `q`=0.
